linear_layer_scheduler: RTL and testbench

Sequencing controller for one fully-connected layer pass. On `start` it clears and streams the serial weight fetcher through all M*TEMP BRAM lines and tracks the fetcher's 2-cycle read latency. It tags each fetched word with row and chunk indices and strobes the downstream MAC array, with first/last-chunk marks. Completed rows go out through a valid/ready handshake with backpressure, and a `done` pulse follows acceptance of the last row.

---
 rtl/linear_layer_scheduler.sv | 171 +++++++++++++++++
 tb/tb_linear_layer_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/linear_layer_scheduler.sv
// linear_layer_scheduler
// Sequencing controller for one fully-connected layer pass. It clears and
// streams a serial weight fetcher through M*TEMP BRAM lines, follows the
// fetcher read latency with a tag pipe, strobes the MAC array with
// first/last-chunk marks, and hands finished rows downstream.
//
// Row output handshake: out_row is offered while row_valid is high and is
// transferred on the rising edge where row_valid && row_ready are both high.
// Once raised, row_valid and out_row hold steady until that transfer.
module linear_layer_scheduler #(
    parameter int M         = 5,
    parameter int TEMP      = 2,
    parameter int FETCH_LAT = 2,
    localparam int RW = (M > 1) ? $clog2(M) : 1,
    localparam int CW = (TEMP > 1) ? $clog2(TEMP) : 1
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          start,
    output logic          busy,
    output logic          fetch_clr,
    output logic          fetch_ce,
    output logic          mac_en,
    output logic          mac_first,
    output logic          mac_last,
    output logic [CW-1:0] chunk_idx,
    output logic [RW-1:0] row_idx,
    output logic          row_valid,
    input  logic          row_ready,
    output logic [RW-1:0] out_row,
    output logic          done,
    output logic [1:0]    dbg_state
);

    localparam int DW = $clog2(FETCH_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_DRAIN    = 2'd2,
        S_WAIT_OUT = 2'd3
    } state_t;

    state_t state;

    // Issue counter kept as row/chunk pair so the tag needs no divider.
    logic [RW-1:0] iss_row;
    logic [CW-1:0] iss_chunk;
    logic [DW-1:0] drain_cnt;

    // Tag pipe, index 0 is the newest entry, FETCH_LAT-1 is the tail that
    // lines up with the word currently on the fetcher output.
    logic [FETCH_LAT-1:0]         tag_v;
    logic [FETCH_LAT-1:0][RW-1:0] tag_row;
    logic [FETCH_LAT-1:0][CW-1:0] tag_chunk;

    logic          tail_v;
    logic [RW-1:0] tail_row;
    logic [CW-1:0] tail_chunk;
    logic          stall;
    logic          last_issue;

    assign tail_v     = tag_v[FETCH_LAT-1];
    assign tail_row   = tag_row[FETCH_LAT-1];
    assign tail_chunk = tag_chunk[FETCH_LAT-1];
    assign last_issue = (iss_row == RW'(M - 1)) && (iss_chunk == CW'(TEMP - 1));
    assign dbg_state  = state;

    // Fetcher and MAC strobes decoded from state, pipe tail and the row handshake.
    always_comb begin
        busy      = (state != S_IDLE);
        fetch_clr = (state == S_IDLE) && start && clr_n;
        // Any offered-but-unaccepted row freezes the fetcher and the MAC.
        stall     = row_valid && !row_ready;
        fetch_ce  = ((state == S_RUN) || (state == S_DRAIN)) && !stall;
        mac_en    = fetch_ce && tail_v;
        mac_first = mac_en && (tail_chunk == '0);
        mac_last  = mac_en && (tail_chunk == CW'(TEMP - 1));
        chunk_idx = mac_en ? tail_chunk : '0;
        row_idx   = mac_en ? tail_row : '0;
    end

    // Pass sequencing FSM: issue counter, drain counter and the done pulse.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= S_IDLE;
            iss_row   <= '0;
            iss_chunk <= '0;
            drain_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    iss_row   <= '0;
                    iss_chunk <= '0;
                    drain_cnt <= '0;
                    if (start) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (fetch_ce) begin
                        if (iss_chunk == CW'(TEMP - 1)) begin
                            iss_chunk <= '0;
                            iss_row   <= iss_row + RW'(1);
                        end else begin
                            iss_chunk <= iss_chunk + CW'(1);
                        end
                        if (last_issue) begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    // Keep the fetcher running until the last word leaves the pipe.
                    if (fetch_ce) begin
                        drain_cnt <= drain_cnt + DW'(1);
                        if (drain_cnt == DW'(FETCH_LAT - 1)) begin
                            state <= S_WAIT_OUT;
                        end
                    end
                end
                S_WAIT_OUT: begin
                    if (row_valid && row_ready && (out_row == RW'(M - 1))) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Tag pipe: cleared while idle, advances only with the fetcher enable.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            tag_v     <= '0;
            tag_row   <= '0;
            tag_chunk <= '0;
        end else if (state == S_IDLE) begin
            tag_v     <= '0;
            tag_row   <= '0;
            tag_chunk <= '0;
        end else if (fetch_ce) begin
            for (int i = FETCH_LAT - 1; i > 0; i--) begin
                tag_v[i]     <= tag_v[i-1];
                tag_row[i]   <= tag_row[i-1];
                tag_chunk[i] <= tag_chunk[i-1];
            end
            // Only RUN issues real lines; DRAIN pushes bubbles.
            tag_v[0]     <= (state == S_RUN);
            tag_row[0]   <= iss_row;
            tag_chunk[0] <= iss_chunk;
        end
    end

    // Row result register: set by a last-chunk commit, cleared by the handshake.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            row_valid <= 1'b0;
            out_row   <= '0;
        end else if (mac_en && mac_last) begin
            row_valid <= 1'b1;
            out_row   <= tail_row;
        end else if (row_valid && row_ready) begin
            row_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_linear_layer_scheduler.sv
// Bench for linear_layer_scheduler: default instance (M=5, TEMP=2) plus a
// small instance (M=3, TEMP=1). Expected events are queued by the driver and
// popped by negedge monitors.
module tb_linear_layer_scheduler;

    logic clk = 1'b0;
    logic clr_n;
    logic start, row_ready;
    logic start1, ready1;

    logic       busy, fetch_clr, fetch_ce, mac_en, mac_first, mac_last;
    logic [0:0] chunk_idx;
    logic [2:0] row_idx, out_row;
    logic       row_valid, done;
    logic [1:0] dbg_state;

    logic       busy1, fetch_clr1, fetch_ce1, mac_en1, mac_first1, mac_last1;
    logic [0:0] chunk_idx1;
    logic [1:0] row_idx1, out_row1;
    logic       row_valid1, done1;
    logic [1:0] dbg_state1;

    linear_layer_scheduler #(.M(5), .TEMP(2), .FETCH_LAT(2)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .busy(busy),
        .fetch_clr(fetch_clr), .fetch_ce(fetch_ce), .mac_en(mac_en),
        .mac_first(mac_first), .mac_last(mac_last), .chunk_idx(chunk_idx),
        .row_idx(row_idx), .row_valid(row_valid), .row_ready(row_ready),
        .out_row(out_row), .done(done), .dbg_state(dbg_state)
    );

    linear_layer_scheduler #(.M(3), .TEMP(1), .FETCH_LAT(2)) dut1 (
        .clk(clk), .clr_n(clr_n), .start(start1), .busy(busy1),
        .fetch_clr(fetch_clr1), .fetch_ce(fetch_ce1), .mac_en(mac_en1),
        .mac_first(mac_first1), .mac_last(mac_last1), .chunk_idx(chunk_idx1),
        .row_idx(row_idx1), .row_valid(row_valid1), .row_ready(ready1),
        .out_row(out_row1), .done(done1), .dbg_state(dbg_state1)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    logic [31:0] clr_q[$], ce_q[$], mac_q[$], row_q[$], done_q[$];
    logic [31:0] mac1_q[$], row1_q[$], done1_q[$];

    function automatic logic [31:0] pack_mac(input int c, input int r, input int k,
                                             input int f, input int l);
        return 32'((c << 16) | (r << 8) | (k << 4) | (f << 1) | l);
    endfunction

    function automatic logic [31:0] pack_row(input int c, input int r);
        return 32'((c << 16) | r);
    endfunction

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] got);
        checks++;
        failures++;
        $display("FAIL %s: unexpected event %h, expected none (cycle %0d)", name, got, cyc);
    endtask

    // Monitor for the default instance.
    always @(negedge clk) begin
        logic [31:0] g;
        if (fetch_clr) begin
            g = 32'(cyc);
            if (clr_q.size() == 0) unexpected("fetch_clr", g); else cmp("fetch_clr", g, clr_q.pop_front());
        end
        if (fetch_ce) begin
            g = 32'(cyc);
            if (ce_q.size() == 0) unexpected("fetch_ce", g); else cmp("fetch_ce", g, ce_q.pop_front());
        end
        if (mac_en) begin
            g = pack_mac(cyc, int'(row_idx), int'(chunk_idx), int'(mac_first), int'(mac_last));
            if (mac_q.size() == 0) unexpected("mac", g); else cmp("mac", g, mac_q.pop_front());
        end else begin
            cmp("mac_idle_zero", {28'd0, mac_first, mac_last, (row_idx != 0), (chunk_idx != 0)}, 32'd0);
        end
        if (row_valid && row_ready) begin
            g = pack_row(cyc, int'(out_row));
            if (row_q.size() == 0) unexpected("row_out", g); else cmp("row_out", g, row_q.pop_front());
        end
        if (done) begin
            g = 32'(cyc);
            if (done_q.size() == 0) unexpected("done", g); else cmp("done", g, done_q.pop_front());
        end
    end

    // Monitor for the TEMP=1 instance.
    always @(negedge clk) begin
        logic [31:0] g;
        if (mac_en1) begin
            g = pack_mac(cyc, int'(row_idx1), int'(chunk_idx1), int'(mac_first1), int'(mac_last1));
            if (mac1_q.size() == 0) unexpected("mac1", g); else cmp("mac1", g, mac1_q.pop_front());
        end
        if (row_valid1 && ready1) begin
            g = pack_row(cyc, int'(out_row1));
            if (row1_q.size() == 0) unexpected("row_out1", g); else cmp("row_out1", g, row1_q.pop_front());
        end
        if (done1) begin
            g = 32'(cyc);
            if (done1_q.size() == 0) unexpected("done1", g); else cmp("done1", g, done1_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // A stall of l cycles beginning at relative cycle s pushes every nominal
    // event at or after s back by l cycles.
    function automatic int sh(input int c, input int s, input int l);
        return (c >= s) ? c + l : c;
    endfunction

    // Nominal schedule: fetch_clr 0, fetch_ce 1..12, mac 3..12,
    // rows accepted 5,7,9,11,13, done 14. Events at or after cutoff are dropped.
    task automatic expect_pass(input int t0, input int s, input int l, input int cutoff);
        int c;
        if (t0 < cutoff) clr_q.push_back(32'(t0));
        for (int i = 1; i <= 12; i++) begin
            c = t0 + sh(i, s, l);
            if (c < cutoff) ce_q.push_back(32'(c));
        end
        for (int i = 0; i < 10; i++) begin
            c = t0 + sh(3 + i, s, l);
            if (c < cutoff) mac_q.push_back(pack_mac(c, i / 2, i % 2, (i % 2 == 0) ? 1 : 0, (i % 2 == 1) ? 1 : 0));
        end
        for (int r = 0; r < 5; r++) begin
            c = t0 + sh(5 + 2 * r, s, l);
            if (c < cutoff) row_q.push_back(pack_row(c, r));
        end
        c = t0 + sh(14, s, l);
        if (c < cutoff) done_q.push_back(32'(c));
    endtask

    task automatic check_drained(input string name);
        cmp(name, 32'(clr_q.size() + ce_q.size() + mac_q.size() + row_q.size() + done_q.size()
                      + mac1_q.size() + row1_q.size() + done1_q.size()), 32'd0);
    endtask

    task automatic check_zero(input string name);
        cmp(name, {6'd0, busy, fetch_clr, fetch_ce, mac_en, mac_first, mac_last, chunk_idx, row_idx,
                   row_valid, out_row, done, dbg_state,
                   busy1, fetch_clr1, fetch_ce1, mac_en1, row_valid1, out_row1, done1}, 32'd0);
    endtask

    // One pass on the default instance; row_ready low for relative cycles [s, s+l).
    task automatic run_pass(input int s, input int l);
        int t0;
        next_cycle();
        start = 1'b1;
        row_ready = 1'b1;
        t0 = cyc;
        expect_pass(t0, s, l, 1 << 30);
        for (int rel = 1; rel <= 16 + l; rel++) begin
            next_cycle();
            start = 1'b0;
            row_ready = (rel >= s && rel < s + l) ? 1'b0 : 1'b1;
        end
        row_ready = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        clr_n = 1'b0;
        start = 1'b1;
        start1 = 1'b1;
        row_ready = 1'b1;
        ready1 = 1'b1;
        #12;
        check_zero("reset_outputs");
        start = 1'b0;
        start1 = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;

        // Plain pass, no backpressure.
        run_pass(1000, 0);
        check_drained("pass_plain_drained");

        // row_ready low for cycles 5..8.
        run_pass(5, 4);
        check_drained("pass_stall_drained");

        // Last row backpressured during cycles 13..15.
        run_pass(13, 3);
        check_drained("pass_last_stall_drained");

        // start at cycle 3 ignored, start at cycle 14 begins a second pass.
        next_cycle();
        start = 1'b1;
        t0 = cyc;
        expect_pass(t0, 1000, 0, 1 << 30);
        expect_pass(t0 + 14, 1000, 0, 1 << 30);
        for (int rel = 1; rel <= 30; rel++) begin
            next_cycle();
            start = (rel == 3 || rel == 14) ? 1'b1 : 1'b0;
        end
        check_drained("pass_restart_drained");

        // Reset at cycle 7 for two cycles, then a fresh full pass.
        next_cycle();
        start = 1'b1;
        t0 = cyc;
        expect_pass(t0, 1000, 0, t0 + 7);
        for (int rel = 1; rel <= 6; rel++) begin
            next_cycle();
            start = 1'b0;
        end
        next_cycle();
        clr_n = 1'b0;
        #1;
        check_zero("midpass_reset_outputs");
        next_cycle();
        check_zero("midpass_reset_held");
        next_cycle();
        clr_n = 1'b1;
        check_drained("midpass_reset_drained");
        run_pass(1000, 0);
        check_drained("pass_after_reset_drained");

        // TEMP=1, M=3 instance.
        next_cycle();
        start1 = 1'b1;
        t0 = cyc;
        mac1_q.push_back(pack_mac(t0 + 3, 0, 0, 1, 1));
        mac1_q.push_back(pack_mac(t0 + 4, 1, 0, 1, 1));
        mac1_q.push_back(pack_mac(t0 + 5, 2, 0, 1, 1));
        row1_q.push_back(pack_row(t0 + 4, 0));
        row1_q.push_back(pack_row(t0 + 5, 1));
        row1_q.push_back(pack_row(t0 + 6, 2));
        done1_q.push_back(32'(t0 + 7));
        for (int rel = 1; rel <= 9; rel++) begin
            next_cycle();
            start1 = 1'b0;
        end
        check_drained("temp1_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
